// File: rtl/i2c_defs.sv
// Shared I2C controller constants: TX FIFO geometry and register bit positions
// used by the APB decode and status logic.
package i2c_defs;

  localparam int TX_FIFO_DEPTH = 8;
  localparam int TX_FIFO_ABITS = 3;

  // Control register
  localparam int CTRL_FLUSH_BIT = 4;

  // Status register
  localparam int STAT_ERR_CLEAR_BIT  = 7;
  localparam int STAT_TX_FULL_BIT    = 0;
  localparam int STAT_TX_EMPTY_BIT   = 1;
  localparam int STAT_TX_OVERFLOW_BIT  = 2;
  localparam int STAT_TX_UNDERFLOW_BIT = 3;

endpackage

// File: rtl/i2c_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port and one
// asynchronous read port. Contents are never reset; shared by the TX and RX FIFOs.
module i2c_fifo_mem #(
  parameter int DEPTH      = 8,
  parameter int ADDR_BITS  = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_BITS-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/i2c_tx_fifo.sv
// Transmit byte FIFO between APB write decode and the I2C byte shifter, with
// first-word fall-through output, level/full/empty status and sticky error flags.
module i2c_tx_fifo
  import i2c_defs::*;
#(
  parameter int DEPTH      = TX_FIFO_DEPTH,
  parameter int ADDR_BITS  = TX_FIFO_ABITS,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  pclk,
  input  logic                  reset,
  input  logic                  txDataWrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  txFlush,
  input  logic                  errClear,
  input  logic                  txPop,
  output logic [DATA_WIDTH-1:0] txData,
  output logic                  txEmpty,
  output logic                  txFull,
  output logic [ADDR_BITS:0]    txLevel,
  output logic                  txOverflow,
  output logic                  txUnderflow
);

  localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS+1)'(DEPTH);

  logic [ADDR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]    count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  pop_ok, push_ok, ovf_event, unf_event, mem_we;
  logic [DATA_WIDTH-1:0] rd_data;

  // A push into a full FIFO is still accepted when a pop frees the head slot
  // in the same cycle; a pop on an empty FIFO is never rescued by a push.
  assign pop_ok    = txPop && (count_q != '0);
  assign push_ok   = txDataWrite && ((count_q != FULL_COUNT) || pop_ok);
  assign ovf_event = txDataWrite && !push_ok;
  assign unf_event = txPop && (count_q == '0);
  assign mem_we    = push_ok && !txFlush && !reset;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (errClear) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (txFlush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
      if (push_ok && !pop_ok) count_d = count_q + (ADDR_BITS+1)'(1);
      if (pop_ok && !push_ok) count_d = count_q - (ADDR_BITS+1)'(1);
      // Error set has priority over a same-cycle clear.
      if (ovf_event) overflow_d  = 1'b1;
      if (unf_event) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  i2c_fifo_mem #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk  (pclk),
    .we   (mem_we),
    .waddr(wr_ptr_q),
    .wdata(pwdata),
    .raddr(rd_ptr_q),
    .rdata(rd_data)
  );

  assign txData      = (count_q != '0) ? rd_data : '0;
  assign txEmpty     = (count_q == '0);
  assign txFull      = (count_q == FULL_COUNT);
  assign txLevel     = count_q;
  assign txOverflow  = overflow_q;
  assign txUnderflow = underflow_q;

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// Scoreboard bench for i2c_tx_fifo: directed scenarios followed by random traffic,
// checked against a queue-based reference model.
module tb_i2c_tx_fifo;

  localparam int DEPTH = 8;

  logic       pclk = 1'b0;
  logic       reset = 1'b1;
  logic       txDataWrite = 1'b0;
  logic [7:0] pwdata = 8'h00;
  logic       txFlush = 1'b0;
  logic       errClear = 1'b0;
  logic       txPop = 1'b0;
  logic [7:0] txData;
  logic       txEmpty, txFull, txOverflow, txUnderflow;
  logic [3:0] txLevel;

  i2c_tx_fifo dut (
    .pclk       (pclk),
    .reset      (reset),
    .txDataWrite(txDataWrite),
    .pwdata     (pwdata),
    .txFlush    (txFlush),
    .errClear   (errClear),
    .txPop      (txPop),
    .txData     (txData),
    .txEmpty    (txEmpty),
    .txFull     (txFull),
    .txLevel    (txLevel),
    .txOverflow (txOverflow),
    .txUnderflow(txUnderflow)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    string      tag;
    logic [7:0] data;
    int         level;
    bit         ovf;
    bit         unf;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] mq[$];
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string name, input string tag, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s [%s] actual=%0h required=%0h at %0t", name, tag, act, req, $time);
    end
  endtask

  // Reference model: the FIFO is a plain queue with a capacity of DEPTH.
  task automatic model(input bit rst, input bit wr, input logic [7:0] d,
                       input bit fl, input bit clr, input bit pop);
    int  n;
    bit  pop_ok, push_ok;
    n = mq.size();
    if (rst) begin
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (fl) begin
      mq.delete();
      if (clr) begin m_ovf = 0; m_unf = 0; end
    end else begin
      pop_ok  = pop && (n > 0);
      push_ok = wr && (n < DEPTH || pop_ok);
      if (pop_ok) void'(mq.pop_front());
      if (push_ok) mq.push_back(d);
      if (clr) begin m_ovf = 0; m_unf = 0; end
      if (wr && !push_ok) m_ovf = 1;
      if (pop && n == 0) m_unf = 1;
    end
  endtask

  task automatic cyc(input string tag, input bit rst, input bit wr, input logic [7:0] d,
                     input bit fl, input bit clr, input bit pop);
    exp_t e;
    @(negedge pclk);
    reset = rst; txDataWrite = wr; pwdata = d; txFlush = fl; errClear = clr; txPop = pop;
    model(rst, wr, d, fl, clr, pop);
    e.tag   = tag;
    e.level = mq.size();
    e.data  = (mq.size() > 0) ? mq[0] : 8'h00;
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    expq.push_back(e);
  endtask

  task automatic push(input string tag, input logic [7:0] d);
    cyc(tag, 0, 1, d, 0, 0, 0);
  endtask

  task automatic pop1(input string tag);
    cyc(tag, 0, 0, 8'h00, 0, 0, 1);
  endtask

  // Monitor: compares the DUT state after each edge that followed a stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge pclk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("level", e.tag, int'(txLevel), e.level);
        chk("data", e.tag, int'(txData), int'(e.data));
        chk("empty", e.tag, int'(txEmpty), int'(e.level == 0));
        chk("full", e.tag, int'(txFull), int'(e.level == DEPTH));
        chk("overflow", e.tag, int'(txOverflow), int'(e.ovf));
        chk("underflow", e.tag, int'(txUnderflow), int'(e.unf));
      end
    end
  end

  initial begin
    int waited;
    cyc("reset", 1, 0, 8'h00, 0, 0, 0);
    cyc("reset2", 1, 1, 8'h99, 0, 0, 1);

    for (int i = 0; i < 8; i++) push("fill", 8'h11 + 8'(i));
    push("overflow", 8'hAA);
    cyc("errclear", 0, 0, 8'h00, 0, 1, 0);
    cyc("full_push_pop", 0, 1, 8'h55, 0, 0, 1);
    for (int i = 0; i < 8; i++) pop1("drain");
    cyc("empty_push_pop", 0, 1, 8'h66, 0, 0, 1);
    pop1("pop66");
    cyc("clr", 0, 0, 8'h00, 0, 1, 0);
    cyc("unf_clr_collide", 0, 0, 8'h00, 0, 1, 1);
    cyc("clr2", 0, 0, 8'h00, 0, 1, 0);

    for (int i = 0; i < 5; i++) push("wrap_pre", 8'hC0 + 8'(i));
    for (int i = 0; i < 5; i++) pop1("wrap_pre_pop");
    for (int i = 0; i < 6; i++) push("wrap", 8'h21 + 8'(i));
    for (int i = 0; i < 6; i++) pop1("wrap_pop");

    for (int i = 0; i < 4; i++) push("lvl4", 8'h40 + 8'(i));
    cyc("flush_write", 0, 1, 8'hEE, 1, 0, 0);
    pop1("after_flush");

    for (int i = 0; i < 8; i++) push("refill", 8'h70 + 8'(i));
    push("ovf2", 8'hBB);
    for (int i = 0; i < 5; i++) pop1("to_lvl3");
    cyc("reset_mid", 1, 0, 8'h00, 0, 0, 0);
    pop1("after_reset");

    for (int i = 0; i < 600; i++) begin
      int r;
      bit wr, pop, fl, clr, rst;
      r   = int'($urandom_range(0, 99));
      wr  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 65 : 35));
      pop = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 65));
      fl  = (r < 3);
      clr = (r >= 3 && r < 10);
      rst = (r == 99);
      cyc("random", rst, wr, 8'($urandom), fl, clr, pop);
    end

    @(negedge pclk);
    reset = 0; txDataWrite = 0; txFlush = 0; errClear = 0; txPop = 0;
    waited = 0;
    while (expq.size() > 0 && waited < 100) begin
      @(negedge pclk);
      waited++;
    end
    if (expq.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout actual=%0d required=0 pending", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
